axi_wr_txn_arbiter: RTL

- Round-robin arbiter and scheduler that shares the write half of the AXI master decoder interface among NUM_REQ local requesters.
- Grants one requester, registers its write command onto the decoder write-control signals, and pulses wr_trn_en.
- Tracks the single outstanding transaction until the matching write response returns or a timeout expires, then reports completion to the owning requester.
- Sits between the requester logic (DMA and register engines) and the AXI master write-control FSM.

---
 rtl/axi_wr_txn_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/axi_wr_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_wr_txn_arbiter
// Function : round-robin arbiter that shares the AXI master write-control port
//            among local requesters and tracks one outstanding transaction.
// Revision : 1.0 - initial release
// ============================================================================
module axi_wr_txn_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int TIMEOUT    = 1024
) (
  input  logic                          AClk,
  input  logic                          ARst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]          req_len,
  input  logic [NUM_REQ*3-1:0]          req_size,
  input  logic [NUM_REQ*2-1:0]          req_burst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*8-1:0]          req_wstrb,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [NUM_REQ-1:0]            req_done,
  output logic [1:0]                    req_bresp,
  output logic                          req_timeout,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [3:0]                    TXN_ID_W_d,
  output logic [ADDR_WIDTH-1:0]         awaddr_d,
  output logic [7:0]                    awlen_d,
  output logic [2:0]                    awsize_d,
  output logic [1:0]                    awburst_d,
  output logic [1:0]                    awlock_d,
  output logic [1:0]                    awcache_d,
  output logic [2:0]                    awprot_d,
  output logic [DATA_WIDTH-1:0]         wdata_d,
  output logic [7:0]                    wstrb_d,
  output logic                          wr_trn_en,
  input  logic [3:0]                    bid_d,
  input  logic [1:0]                    bresp_d,
  input  logic                          wr_rsp_en_d
);

  localparam int IDX_W = 2;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ISSUE = 2'd1;
  localparam logic [1:0] c_ST_WAIT  = 2'd2;
  localparam logic [1:0] c_ST_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [1:0]       r_seq;
  logic [CNT_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_cand;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_sel_valid;
  logic             w_rsp_match;
  logic             w_expired;

  assign awlock_d  = 2'b00;
  assign awcache_d = 2'b00;
  assign awprot_d  = 3'b000;

  assign w_rsp_match = wr_rsp_en_d && (bid_d == TXN_ID_W_d);
  assign w_expired   = (r_cnt == c_cnt_last);

  // Walk offsets from farthest to nearest so the nearest asserted index after rr_ptr wins.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_idx   = '0;
    w_cand      = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_cand = r_rr_ptr + IDX_W'(i);
      if (req_valid[w_cand]) begin
        w_sel_valid = 1'b1;
        w_sel_idx   = w_cand;
      end
    end
  end

  always_ff @(posedge AClk or posedge ARst) begin
    if (ARst) r_state <= c_ST_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_sel_valid) w_next_state = c_ST_ISSUE;
      c_ST_ISSUE: w_next_state = c_ST_WAIT;
      c_ST_WAIT:  if (w_rsp_match || w_expired) w_next_state = c_ST_DONE;
      c_ST_DONE:  w_next_state = c_ST_IDLE;
      default:    w_next_state = c_ST_IDLE;
    endcase
  end

  always_comb begin
    wr_trn_en = 1'b0;
    req_ack   = '0;
    req_done  = '0;
    case (r_state)
      c_ST_ISSUE: begin
        wr_trn_en = 1'b1;
        req_ack   = gnt;
      end
      c_ST_DONE: req_done = gnt;
      default:   ;
    endcase
  end

  always_ff @(posedge AClk or posedge ARst) begin
    if (ARst) begin
      r_rr_ptr    <= 2'd3;
      r_seq       <= 2'd0;
      r_cnt       <= '0;
      gnt         <= '0;
      TXN_ID_W_d  <= '0;
      awaddr_d    <= '0;
      awlen_d     <= '0;
      awsize_d    <= '0;
      awburst_d   <= '0;
      req_bresp   <= '0;
      req_timeout <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_sel_valid) begin
            r_rr_ptr   <= w_sel_idx;
            gnt        <= NUM_REQ'(1) << w_sel_idx;
            TXN_ID_W_d <= {r_seq, w_sel_idx};
            awaddr_d   <= req_addr[w_sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
            awlen_d    <= req_len[w_sel_idx*8 +: 8];
            awsize_d   <= req_size[w_sel_idx*3 +: 3];
            awburst_d  <= req_burst[w_sel_idx*2 +: 2];
          end
        end
        c_ST_ISSUE: r_cnt <= '0;
        c_ST_WAIT: begin
          // A matching response beats expiry in the same cycle.
          if (w_rsp_match) begin
            req_bresp   <= bresp_d;
            req_timeout <= 1'b0;
          end else if (w_expired) begin
            req_bresp   <= 2'b10;
            req_timeout <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        c_ST_DONE: begin
          r_seq       <= r_seq + 2'd1;
          gnt         <= '0;
          req_timeout <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wdata_d = '0;
    wstrb_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        wdata_d = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        wstrb_d = req_wstrb[i*8 +: 8];
      end
    end
  end

endmodule
`default_nettype wire
